recon_capture_sched: RTL and testbench
======================================

# recon_capture_sched

Control-plane scheduler for the reconfiguration capture datapath. Consumes decoded reconfiguration headers (function, bitstream id, size), allocates and tracks DDR regions in a per-id bitstream table, hands the base address to the stream-to-AXI capture path, and issues DMA load commands for stored bitstreams. It serialises all requests: one capture or load in flight at a time.

## Interface
- ADDR_WIDTH, 34, DDR byte-address width
- ID_WIDTH, 4, table index width; NUM_IDS = 2**ID_WIDTH entries
- REGION_BYTES, 2**32, capture region size in bytes, starting at address 0
- ALIGN_LOG2, 12, allocation granularity is 2**ALIGN_LOG2 bytes

Ports:
- s_axis_clk  in  1  clock; all logic in this domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  header request valid
- req_ready  out  1  high only in IDLE
- req_func  in  2  00 store, 01 load, 10 invalidate, 11 reserved
- req_id  in  8  bitstream id; 8'hFF with func 10 means clear-all
- req_size  in  32  bitstream size in bytes
- req_size_valid  in  1  req_size field valid
- cap_addr_valid  out  1  base address offered to capture path
- cap_addr  out  ADDR_WIDTH  allocated base address
- cap_ack  in  1  capture path accepted cap_addr
- cap_done  in  1  one-cycle pulse: capture finished
- cap_bytes  in  32  bytes written, valid with cap_done
- dma_cmd_valid  out  1  load command valid
- dma_cmd_ready  in  1  DMA engine accepts command
- dma_cmd_addr  out  ADDR_WIDTH  stored base address
- dma_cmd_len  out  32  stored size in bytes
- dma_cmd_id  out  8  bitstream id
- dma_done  in  1  one-cycle pulse: load finished
- status_err  out  1  one-cycle error pulse
- status_code  out  3  last error code, held until next error
- busy  out  1  FSM not in IDLE
- free_ptr  out  ADDR_WIDTH  next unallocated byte address

## Operation
- Table entry per id: valid, base[ADDR_WIDTH], size[32]. All invalid on reset.
- FSM states: IDLE, CHECK, CAP_ADDR, CAP_WAIT, DMA_CMD, DMA_WAIT.
- IDLE: req_ready=1; on req_valid latch func/id/size/size_valid and go to CHECK.
- CHECK (one cycle), in priority order:
  - func 11 -> error 3, IDLE.
  - func 10, id 8'hFF -> all entries invalid, free_ptr=0, IDLE. Other id >= NUM_IDS -> error 1. Else clear that entry's valid bit (free_ptr unchanged), IDLE.
  - id >= NUM_IDS -> error 1, IDLE.
  - store: !size_valid or size==0 -> error 2. rsz = size rounded up to 2**ALIGN_LOG2. If entry valid and entry.size >= size, reuse entry.base (free_ptr unchanged). Else, if free_ptr + rsz > REGION_BYTES -> error 4; otherwise base=free_ptr, free_ptr += rsz. Entry valid cleared on successful allocation. -> CAP_ADDR.
  - load: entry invalid -> error 6, else -> DMA_CMD.
- CAP_ADDR: cap_addr_valid=1 with base held stable until cap_ack, then CAP_WAIT. If cap_done is asserted in the same cycle as cap_ack, it is honoured as in CAP_WAIT.
- CAP_WAIT: on cap_done, if cap_bytes == size, set entry {1, base, size}; else error 5 and entry stays invalid; allocated space is not reclaimed. -> IDLE.
- DMA_CMD: dma_cmd_valid=1 with addr/len/id stable until dma_cmd_ready -> DMA_WAIT. DMA_WAIT: on dma_done -> IDLE.
- cap_done and dma_done outside their wait states are ignored.
- Arithmetic: free_ptr + rsz is computed at ADDR_WIDTH+1 bits with no wrap.

## Timing
- Reset values: req_ready=0 during reset, then 1 the cycle after; cap_addr_valid=0, dma_cmd_valid=0, status_err=0, status_code=0, busy=0, free_ptr=0, cap_addr=0, dma_cmd_*=0.
- Request accepted at edge N. CHECK is active in cycle N+1. cap_addr_valid or dma_cmd_valid rises at N+2. status_err pulses at N+2 for CHECK errors.
- Error 5 pulse occurs the cycle after cap_done. The table update is visible to a CHECK starting one cycle after returning to IDLE.
- Minimum turnaround: IDLE is re-entered the cycle after the completing handshake or pulse.
- Reset mid-operation: FSM goes to IDLE, table is cleared, outstanding handshakes are abandoned and no pulses are emitted.

## Test plan
- Store id 3, size 5000 -> cap_addr=0 at N+2; cap_ack; cap_done with cap_bytes=5000 -> entry valid, free_ptr=8192.
- Second store id 4, size 100 -> cap_addr=8192, free_ptr=12288. Then load id 3 -> dma_cmd_addr=0, len=5000, id=3; hold dma_cmd_ready low 5 cycles -> outputs stable.
- Re-store id 3, size 4000 -> base 0 reused, free_ptr unchanged. cap_bytes=3999 -> status_err with code 5; a following load of id 3 gives code 6.
- Errors: id 20 store -> code 1. size_valid=0 -> code 2. func 11 -> code 3. Size exceeding remaining REGION_BYTES -> code 4 with free_ptr unchanged.
- Invalidate id 4, then load id 4 -> code 6. Clear-all (id 8'hFF) -> free_ptr=0, and a next store lands at 0.
- Assert rst while in CAP_WAIT -> next cycle busy=0, cap_addr_valid=0; a late cap_done is ignored; load of id 3 gives code 6.

Source files
------------

// File: rtl/recon_capture_sched.sv
// recon_capture_sched: serialising scheduler that allocates DDR regions per
// bitstream id, offers capture base addresses and issues DMA load commands.
module recon_capture_sched #(
  parameter int unsigned     ADDR_WIDTH   = 34,
  parameter int unsigned     ID_WIDTH     = 4,
  parameter longint unsigned REGION_BYTES = 64'h1_0000_0000,
  parameter int unsigned     ALIGN_LOG2   = 12
) (
  input  logic                  s_axis_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_func,
  input  logic [7:0]            req_id,
  input  logic [31:0]           req_size,
  input  logic                  req_size_valid,
  output logic                  cap_addr_valid,
  output logic [ADDR_WIDTH-1:0] cap_addr,
  input  logic                  cap_ack,
  input  logic                  cap_done,
  input  logic [31:0]           cap_bytes,
  output logic                  dma_cmd_valid,
  input  logic                  dma_cmd_ready,
  output logic [ADDR_WIDTH-1:0] dma_cmd_addr,
  output logic [31:0]           dma_cmd_len,
  output logic [7:0]            dma_cmd_id,
  input  logic                  dma_done,
  output logic                  status_err,
  output logic [2:0]            status_code,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] free_ptr
);

  localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;
  localparam int unsigned SUM_W   = ADDR_WIDTH + 1;
  localparam logic [32:0]      ALIGN_MASK = 33'((64'd1 << ALIGN_LOG2) - 64'd1);
  localparam logic [SUM_W-1:0] REGION_LIM = SUM_W'(REGION_BYTES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_CAP_ADDR = 3'd2;
  localparam logic [2:0] S_CAP_WAIT = 3'd3;
  localparam logic [2:0] S_DMA_CMD  = 3'd4;
  localparam logic [2:0] S_DMA_WAIT = 3'd5;

  logic [2:0]            state, state_n;
  logic [1:0]            l_func;
  logic [7:0]            l_id;
  logic [31:0]           l_size;
  logic                  l_size_valid;
  logic [ADDR_WIDTH-1:0] l_base;

  logic [NUM_IDS-1:0]    tbl_valid;
  logic [ADDR_WIDTH-1:0] tbl_base [NUM_IDS];
  logic [31:0]           tbl_size [NUM_IDS];

  logic [ID_WIDTH-1:0]   idx;
  logic                  id_oob;
  logic                  reuse;
  logic [32:0]           rsz;
  logic [SUM_W-1:0]      sum;
  logic [ADDR_WIDTH-1:0] alloc_base;

  logic       acc, clr_all, inval, alloc, bump, commit, load_go, err;
  logic [2:0] err_code;

  // Request-derived helpers: table index, range check, rounded size, new pointer.
  always_comb begin
    idx        = l_id[ID_WIDTH-1:0];
    id_oob     = 32'(l_id) >= NUM_IDS;
    reuse      = tbl_valid[idx] && (tbl_size[idx] >= l_size);
    rsz        = (33'(l_size) + ALIGN_MASK) & ~ALIGN_MASK;
    sum        = SUM_W'(free_ptr) + SUM_W'(rsz);
    alloc_base = reuse ? tbl_base[idx] : free_ptr;
  end

  // State register.
  always_ff @(posedge s_axis_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and action decode.
  always_comb begin
    state_n  = state;
    acc      = 1'b0;
    clr_all  = 1'b0;
    inval    = 1'b0;
    alloc    = 1'b0;
    bump     = 1'b0;
    commit   = 1'b0;
    load_go  = 1'b0;
    err      = 1'b0;
    err_code = 3'd0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          acc     = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        state_n = S_IDLE;
        if (l_func == 2'b11) begin
          err = 1'b1; err_code = 3'd3;
        end else if (l_func == 2'b10) begin
          if (l_id == 8'hFF) clr_all = 1'b1;
          else if (id_oob) begin err = 1'b1; err_code = 3'd1; end
          else inval = 1'b1;
        end else if (id_oob) begin
          err = 1'b1; err_code = 3'd1;
        end else if (l_func == 2'b00) begin
          if (!l_size_valid || l_size == 32'd0) begin
            err = 1'b1; err_code = 3'd2;
          end else if (reuse) begin
            alloc = 1'b1; state_n = S_CAP_ADDR;
          end else if (sum > REGION_LIM) begin
            err = 1'b1; err_code = 3'd4;
          end else begin
            alloc = 1'b1; bump = 1'b1; state_n = S_CAP_ADDR;
          end
        end else begin
          if (!tbl_valid[idx]) begin err = 1'b1; err_code = 3'd6; end
          else begin load_go = 1'b1; state_n = S_DMA_CMD; end
        end
      end
      S_CAP_ADDR: begin
        if (cap_ack) begin
          if (cap_done) begin
            state_n = S_IDLE;
            if (cap_bytes == l_size) commit = 1'b1;
            else begin err = 1'b1; err_code = 3'd5; end
          end else begin
            state_n = S_CAP_WAIT;
          end
        end
      end
      S_CAP_WAIT: begin
        if (cap_done) begin
          state_n = S_IDLE;
          if (cap_bytes == l_size) commit = 1'b1;
          else begin err = 1'b1; err_code = 3'd5; end
        end
      end
      S_DMA_CMD:  if (dma_cmd_ready) state_n = S_DMA_WAIT;
      S_DMA_WAIT: if (dma_done) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Request latch, bitstream table, allocation pointer and registered outputs.
  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      l_func         <= 2'd0;
      l_id           <= 8'd0;
      l_size         <= 32'd0;
      l_size_valid   <= 1'b0;
      l_base         <= '0;
      tbl_valid      <= '0;
      free_ptr       <= '0;
      req_ready      <= 1'b0;
      busy           <= 1'b0;
      cap_addr_valid <= 1'b0;
      cap_addr       <= '0;
      dma_cmd_valid  <= 1'b0;
      dma_cmd_addr   <= '0;
      dma_cmd_len    <= 32'd0;
      dma_cmd_id     <= 8'd0;
      status_err     <= 1'b0;
      status_code    <= 3'd0;
    end else begin
      if (acc) begin
        l_func       <= req_func;
        l_id         <= req_id;
        l_size       <= req_size;
        l_size_valid <= req_size_valid;
      end
      if (alloc) begin
        l_base         <= alloc_base;
        cap_addr       <= alloc_base;
        tbl_valid[idx] <= 1'b0;
      end
      if (bump) free_ptr <= ADDR_WIDTH'(sum);
      if (clr_all) begin
        tbl_valid <= '0;
        free_ptr  <= '0;
      end
      if (inval) tbl_valid[idx] <= 1'b0;
      if (commit) begin
        tbl_valid[idx] <= 1'b1;
        tbl_base[idx]  <= l_base;
        tbl_size[idx]  <= l_size;
      end
      if (load_go) begin
        dma_cmd_addr <= tbl_base[idx];
        dma_cmd_len  <= tbl_size[idx];
        dma_cmd_id   <= l_id;
      end
      status_err <= err;
      if (err) status_code <= err_code;
      req_ready      <= (state_n == S_IDLE);
      busy           <= (state_n != S_IDLE);
      cap_addr_valid <= (state_n == S_CAP_ADDR);
      dma_cmd_valid  <= (state_n == S_DMA_CMD);
    end
  end

endmodule

// File: tb/tb_recon_capture_sched.sv
// tb_recon_capture_sched: randomized scoreboard bench with a table/pointer model.
module tb_recon_capture_sched;

  logic        s_axis_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_func = 2'd0;
  logic [7:0]  req_id = 8'd0;
  logic [31:0] req_size = 32'd0;
  logic        req_size_valid = 1'b0;
  logic        cap_addr_valid;
  logic [33:0] cap_addr;
  logic        cap_ack = 1'b0;
  logic        cap_done = 1'b0;
  logic [31:0] cap_bytes = 32'd0;
  logic        dma_cmd_valid;
  logic        dma_cmd_ready = 1'b0;
  logic [33:0] dma_cmd_addr;
  logic [31:0] dma_cmd_len;
  logic [7:0]  dma_cmd_id;
  logic        dma_done = 1'b0;
  logic        status_err;
  logic [2:0]  status_code;
  logic        busy;
  logic [33:0] free_ptr;

  always #5 s_axis_clk = ~s_axis_clk;

  recon_capture_sched dut (
    .s_axis_clk(s_axis_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_id(req_id), .req_size(req_size), .req_size_valid(req_size_valid),
    .cap_addr_valid(cap_addr_valid), .cap_addr(cap_addr), .cap_ack(cap_ack),
    .cap_done(cap_done), .cap_bytes(cap_bytes),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_addr(dma_cmd_addr), .dma_cmd_len(dma_cmd_len), .dma_cmd_id(dma_cmd_id),
    .dma_done(dma_done), .status_err(status_err), .status_code(status_code),
    .busy(busy), .free_ptr(free_ptr)
  );

  // kind: 0 capture offer (a=addr), 1 dma command (a=addr,b=len,c=id), 2 error (c=code)
  typedef struct {
    int     kind;
    longint a;
    longint b;
    int     c;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  bit     m_valid [16];
  longint m_base  [16];
  longint m_size  [16];
  longint m_free = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_free = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin : monitor
    exp_t   e;
    bit     prev_cav = 1'b0, prev_dcv = 1'b0;
    longint cap_hold = 0, d_a = 0, d_b = 0;
    int     d_c = 0;
    forever begin
      @(negedge s_axis_clk);
      if (!rst) begin
        if (cap_addr_valid) begin
          if (!prev_cav) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL cap_unexpected: got addr %0d expected no event", cap_addr);
            end else begin
              e = q.pop_front();
              chk("cap_kind", 64'(e.kind), 64'd0);
              chk("cap_addr", 64'(cap_addr), 64'(e.a));
              cap_hold = e.a;
            end
          end else chk("cap_stable", 64'(cap_addr), 64'(cap_hold));
        end
        if (dma_cmd_valid) begin
          if (!prev_dcv) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL dma_unexpected: got addr %0d expected no event", dma_cmd_addr);
            end else begin
              e = q.pop_front();
              chk("dma_kind", 64'(e.kind), 64'd1);
              d_a = e.a; d_b = e.b; d_c = e.c;
            end
          end
          chk("dma_addr", 64'(dma_cmd_addr), 64'(d_a));
          chk("dma_len",  64'(dma_cmd_len),  64'(d_b));
          chk("dma_id",   64'(dma_cmd_id),   64'(d_c));
        end
        if (status_err) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL err_unexpected: got code %0d expected no event", status_code);
          end else begin
            e = q.pop_front();
            chk("err_kind", 64'(e.kind), 64'd2);
            chk("err_code", 64'(status_code), 64'(e.c));
          end
        end
      end
      prev_cav = cap_addr_valid;
      prev_dcv = dma_cmd_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !busy) && n < 40) begin
      @(negedge s_axis_clk);
      n++;
    end
    checks++;
    if (!(req_ready && !busy)) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0d req_ready=%0d expected idle", busy, req_ready);
    end
    chk("free_ptr", 64'(free_ptr), 64'(m_free));
  endtask

  // One request end to end: model prediction, drive, play capture/DMA side.
  task automatic do_op(input logic [1:0] f, input logic [7:0] id, input logic [31:0] sz,
                       input logic sv, input bit bad_len, input int hold, input bit same,
                       input bit abort);
    exp_t   e;
    bit     ok_cap = 1'b0, ok_dma = 1'b0;
    longint rsz, base = 0;
    int     ix = int'(id);
    logic [3:0] lat;
    e = '{2, 0, 0, 0};
    if (f == 2'b11) e.c = 3;
    else if (f == 2'b10) begin
      if (id == 8'hFF) model_reset();
      else if (ix >= 16) e.c = 1;
      else m_valid[ix] = 1'b0;
    end else if (ix >= 16) e.c = 1;
    else if (f == 2'b00) begin
      if (!sv || sz == 0) e.c = 2;
      else begin
        rsz = ((longint'(sz) + 4095) / 4096) * 4096;
        if (m_valid[ix] && m_size[ix] >= longint'(sz)) begin base = m_base[ix]; ok_cap = 1'b1; end
        else if (m_free + rsz > 64'h1_0000_0000) e.c = 4;
        else begin base = m_free; m_free = m_free + rsz; ok_cap = 1'b1; end
        if (ok_cap) m_valid[ix] = 1'b0;
      end
    end else begin
      if (!m_valid[ix]) e.c = 6;
      else ok_dma = 1'b1;
    end
    if (ok_cap) begin q.push_back('{0, base, 0, 0}); lat = 4'b1000; end
    else if (ok_dma) begin q.push_back('{1, m_base[ix], m_size[ix], ix}); lat = 4'b0100; end
    else if (e.c != 0) begin q.push_back(e); lat = 4'b0011; end
    else lat = 4'b0001;

    req_valid = 1'b1; req_func = f; req_id = id; req_size = sz; req_size_valid = sv;
    @(negedge s_axis_clk);
    req_valid = 1'b0;
    chk("check_busy", {63'd0, busy & ~req_ready}, 64'd1);
    @(negedge s_axis_clk);
    chk("latency", 64'({cap_addr_valid, dma_cmd_valid, status_err, req_ready}), 64'(lat));

    if (ok_cap) begin
      repeat ($urandom_range(0, 3)) @(negedge s_axis_clk);
      cap_ack = 1'b1;
      if (same && !abort) begin
        cap_done = 1'b1;
        cap_bytes = bad_len ? sz - 32'd1 : sz;
        if (bad_len) q.push_back('{2, 0, 0, 5});
        else begin m_valid[ix] = 1'b1; m_base[ix] = base; m_size[ix] = longint'(sz); end
      end
      @(negedge s_axis_clk);
      cap_ack = 1'b0; cap_done = 1'b0;
      if (abort) begin
        rst = 1'b1;
        @(negedge s_axis_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cav", 64'(cap_addr_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_free", 64'(free_ptr), 64'd0);
        rst = 1'b0;
        model_reset();
        @(negedge s_axis_clk);
        chk("rst_ready_after", 64'(req_ready), 64'd1);
        cap_done = 1'b1; cap_bytes = sz;
        @(negedge s_axis_clk);
        cap_done = 1'b0;
        chk("late_done_err", 64'(status_err), 64'd0);
        chk("late_done_busy", 64'(busy), 64'd0);
      end else if (!same) begin
        repeat ($urandom_range(0, 3)) @(negedge s_axis_clk);
        cap_done = 1'b1;
        cap_bytes = bad_len ? sz - 32'd1 : sz;
        if (bad_len) q.push_back('{2, 0, 0, 5});
        else begin m_valid[ix] = 1'b1; m_base[ix] = base; m_size[ix] = longint'(sz); end
        @(negedge s_axis_clk);
        cap_done = 1'b0;
      end
    end
    if (ok_dma) begin
      repeat (hold) @(negedge s_axis_clk);
      dma_cmd_ready = 1'b1;
      @(negedge s_axis_clk);
      dma_cmd_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge s_axis_clk);
      dma_done = 1'b1;
      @(negedge s_axis_clk);
      dma_done = 1'b0;
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          r;
    logic [1:0]  f;
    logic [7:0]  id;
    logic [31:0] sz;
    logic        sv;
    model_reset();
    repeat (3) @(negedge s_axis_clk);
    chk("reset_outputs", 64'({req_ready, cap_addr_valid, dma_cmd_valid, status_err, busy}), 64'd0);
    chk("reset_code", 64'(status_code), 64'd0);
    chk("reset_free", 64'(free_ptr), 64'd0);
    chk("reset_capaddr", 64'(cap_addr), 64'd0);
    chk("reset_dma", 64'({dma_cmd_addr, dma_cmd_len, dma_cmd_id}), 64'd0);
    rst = 1'b0;
    @(negedge s_axis_clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    do_op(2'b00, 8'd3, 32'd5000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("free_8192", 64'(free_ptr), 64'd8192);
    do_op(2'b00, 8'd4, 32'd100, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    chk("free_12288", 64'(free_ptr), 64'd12288);
    do_op(2'b01, 8'd3, 32'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    do_op(2'b00, 8'd3, 32'd4000, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    do_op(2'b01, 8'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b00, 8'd20, 32'd64, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b00, 8'd5, 32'd64, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b11, 8'd5, 32'd64, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b00, 8'd6, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b10, 8'd4, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b01, 8'd4, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b10, 8'hFF, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("clear_all_free", 64'(free_ptr), 64'd0);
    do_op(2'b00, 8'd7, 32'd4096, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_op(2'b00, 8'd3, 32'd5000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    do_op(2'b01, 8'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r  = int'($urandom_range(0, 15));
      id = ($urandom_range(0, 9) == 0) ? 8'(16 + $urandom_range(0, 238)) : 8'($urandom_range(0, 15));
      sz = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 20000));
      sv = ($urandom_range(0, 15) != 0);
      if (r <= 6) f = 2'b00;
      else if (r <= 10) f = 2'b01;
      else if (r <= 12) f = 2'b10;
      else if (r == 13) begin f = 2'b10; id = 8'hFF; end
      else if (r == 14) f = 2'b11;
      else begin f = 2'b00; sz = 32'hF000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF)); end
      do_op(f, id, sz, sv, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
            ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (3) @(negedge s_axis_clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
